rand_arbiter: RTL and testbench

//  Round-robin scheduler that shares one random-generator engine (controller +

---
 rtl/rand_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_rand_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_arbiter.sv
// rand_arbiter
//   Round-robin scheduler that shares one random-generator engine among
//   NUM_REQ requesters. A winner is picked from req while idle, and its seed
//   is latched and presented to the engine together with a one-cycle start
//   pulse. The scheduler then waits for eng_done, bounded by TIMEOUT cycles,
//   and returns the engine data/result to the winner with a one-hot
//   resp_valid pulse. A timeout returns zero data with resp_err set.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   req           level requests, sampled only while idle
//   seed_in       packed seeds, requester i at [i*DATA_W +: DATA_W]
//   gnt           one-hot, one-cycle grant pulse
//   resp_valid    one-hot, one-cycle response pulse to the winner
//   resp_data     engine data (0 on timeout), qualified by resp_valid
//   resp_result   engine result (0 on timeout), qualified by resp_valid
//   resp_err      timeout flag, qualified by resp_valid
//   busy          high whenever the scheduler is not idle
//   eng_start     one-cycle engine start pulse
//   eng_data_in   latched seed of the current winner
//   eng_data_out  engine data input
//   eng_result    engine result input
//   eng_done      engine completion, only honoured while waiting
module rand_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 6,
  parameter int RES_W   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] seed_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic [RES_W-1:0]          resp_result,
  output logic                      resp_err,
  output logic                      busy,
  output logic                      eng_start,
  output logic [DATA_W-1:0]         eng_data_in,
  input  logic [DATA_W-1:0]         eng_data_out,
  input  logic [RES_W-1:0]          eng_result,
  input  logic                      eng_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     winner_q, winner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]    resp_data_q, resp_data_d;
  logic [RES_W-1:0]     resp_result_q, resp_result_d;
  logic                 resp_err_q, resp_err_d;
  logic                 busy_q, busy_d;
  logic                 eng_start_q, eng_start_d;
  logic [DATA_W-1:0]    eng_data_in_q, eng_data_in_d;

  logic [DATA_W-1:0]    seed_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_seed
    assign seed_arr[g] = seed_in[g*DATA_W +: DATA_W];
  end

  // First set request at or above ptr, wrapping NUM_REQ-1 -> 0.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                            input logic [IDX_W-1:0]   ptr);
    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    pick  = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (!found && r[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    winner_d      = winner_q;
    cnt_d         = cnt_q;
    gnt_d         = '0;
    eng_start_d   = 1'b0;
    resp_valid_d  = '0;
    resp_data_d   = resp_data_q;
    resp_result_d = resp_result_q;
    resp_err_d    = resp_err_q;
    eng_data_in_d = eng_data_in_q;

    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          winner_d      = pick(req, rr_ptr_q);
          gnt_d         = onehot(winner_d);
          eng_start_d   = 1'b1;
          eng_data_in_d = seed_arr[winner_d];
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // done takes priority over a timeout in the same cycle
        if (eng_done) begin
          resp_data_d   = eng_data_out;
          resp_result_d = eng_result;
          resp_err_d    = 1'b0;
          resp_valid_d  = onehot(winner_q);
          state_d       = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          resp_data_d   = '0;
          resp_result_d = '0;
          resp_err_d    = 1'b1;
          resp_valid_d  = onehot(winner_q);
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        resp_data_d   = '0;
        resp_result_d = '0;
        resp_err_d    = 1'b0;
        rr_ptr_d      = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      winner_q      <= '0;
      cnt_q         <= '0;
      gnt_q         <= '0;
      resp_valid_q  <= '0;
      resp_data_q   <= '0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      eng_start_q   <= 1'b0;
      eng_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      winner_q      <= winner_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_result_q <= resp_result_d;
      resp_err_q    <= resp_err_d;
      busy_q        <= busy_d;
      eng_start_q   <= eng_start_d;
      eng_data_in_q <= eng_data_in_d;
    end
  end

  assign gnt         = gnt_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_result = resp_result_q;
  assign resp_err    = resp_err_q;
  assign busy        = busy_q;
  assign eng_start   = eng_start_q;
  assign eng_data_in = eng_data_in_q;

endmodule

// File: tb/tb_rand_arbiter.sv
// tb_rand_arbiter
//   Directed bench for rand_arbiter (NUM_REQ=4, DATA_W=6, RES_W=2,
//   TIMEOUT=64). The engine side is driven directly by each scenario.
module tb_rand_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [23:0] seed_in;
  logic [3:0]  gnt;
  logic [3:0]  resp_valid;
  logic [5:0]  resp_data;
  logic [1:0]  resp_result;
  logic        resp_err;
  logic        busy;
  logic        eng_start;
  logic [5:0]  eng_data_in;
  logic [5:0]  eng_data_out;
  logic [1:0]  eng_result;
  logic        eng_done;

  int errors = 0;
  int checks = 0;

  // values captured by do_txn
  logic [3:0] cap_gnt, cap_gnt2, cap_rv, cap_rv_after;
  logic       cap_start, cap_start2, cap_busy_gnt, cap_err, cap_busy_after;
  logic [5:0] cap_din, cap_din_late, cap_rd, cap_rd_after;
  logic [1:0] cap_rr;
  int         cap_wait;

  rand_arbiter #(.NUM_REQ(4), .DATA_W(6), .RES_W(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .seed_in(seed_in), .gnt(gnt),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_result(resp_result),
    .resp_err(resp_err), .busy(busy), .eng_start(eng_start),
    .eng_data_in(eng_data_in), .eng_data_out(eng_data_out),
    .eng_result(eng_result), .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction from an idle cycle: present req/seed, run the wait
  // phase with eng_done asserted in WAIT cycle done_at (-1: never), and
  // finish in the idle cycle after the response.
  task automatic do_txn(input logic [3:0] r, input logic [23:0] seeds,
                        input logic hold, input logic stray_issue,
                        input int done_at, input logic [5:0] d,
                        input logic [1:0] res);
    req = r;
    seed_in = seeds;
    step();
    cap_gnt = gnt; cap_start = eng_start; cap_din = eng_data_in; cap_busy_gnt = busy;
    if (!hold) req = '0;
    seed_in = ~seeds;
    if (stray_issue) begin
      eng_done = 1'b1; eng_data_out = 6'h3F; eng_result = 2'b11;
    end
    step();
    cap_gnt2 = gnt; cap_start2 = eng_start;
    cap_wait = -1;
    cap_rv = '0; cap_rd = '0; cap_rr = '0; cap_err = 1'b0; cap_din_late = '0;
    for (int k = 1; k <= 200; k++) begin
      if (k == done_at) begin
        eng_done = 1'b1; eng_data_out = d; eng_result = res;
      end else begin
        eng_done = 1'b0; eng_data_out = ~d; eng_result = ~res;
      end
      cap_din_late = eng_data_in;
      step();
      if (resp_valid !== 4'b0000) begin
        cap_wait = k;
        cap_rv = resp_valid; cap_rd = resp_data; cap_rr = resp_result; cap_err = resp_err;
        break;
      end
    end
    eng_done = 1'b0;
    step();
    cap_rv_after = resp_valid; cap_rd_after = resp_data; cap_busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; seed_in = '0; eng_done = 1'b0;
    eng_data_out = '0; eng_result = '0;
    step(); step();
    checks++;
    if ({gnt, resp_valid, resp_data, resp_result, resp_err, busy, eng_start, eng_data_in} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0",
               {gnt, resp_valid, resp_data, resp_result, resp_err, busy, eng_start, eng_data_in});
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0) begin
      errors++; $display("FAIL reset_idle busy=%b gnt=%b want 0/0000", busy, gnt);
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 8; i++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (i % 4);
      do_txn(4'b1111, {6'h04, 6'h03, 6'h02, 6'h01}, 1'b1, 1'b0, 1, 6'(i * 5 + 1), 2'(i));
      checks++;
      if (cap_gnt !== exp_g) begin
        errors++; $display("FAIL rr_gnt[%0d] got=%b want=%b", i, cap_gnt, exp_g);
      end
      checks++;
      if (cap_din !== 6'(i % 4 + 1)) begin
        errors++; $display("FAIL rr_seed[%0d] got=%h want=%h", i, cap_din, 6'(i % 4 + 1));
      end
      checks++;
      if (cap_wait !== 1 || cap_rv !== exp_g || cap_rd !== 6'(i * 5 + 1) || cap_rr !== 2'(i)) begin
        errors++;
        $display("FAIL rr_resp[%0d] wait=%0d rv=%b data=%h res=%h want 1/%b/%h/%h",
                 i, cap_wait, cap_rv, cap_rd, cap_rr, exp_g, 6'(i * 5 + 1), 2'(i));
      end
    end
    req = '0;
  endtask

  task automatic test_single();
    do_txn(4'b0010, {6'h11, 6'h22, 6'h2A, 6'h33}, 1'b0, 1'b0, 3, 6'h15, 2'b10);
    checks++;
    if (cap_gnt !== 4'b0010 || cap_start !== 1'b1 || cap_busy_gnt !== 1'b1) begin
      errors++; $display("FAIL single_grant gnt=%b start=%b busy=%b want 0010/1/1",
                         cap_gnt, cap_start, cap_busy_gnt);
    end
    checks++;
    if (cap_gnt2 !== 4'b0000 || cap_start2 !== 1'b0) begin
      errors++; $display("FAIL single_pulse gnt=%b start=%b want 0000/0", cap_gnt2, cap_start2);
    end
    checks++;
    if (cap_din !== 6'h2A || cap_din_late !== 6'h2A) begin
      errors++; $display("FAIL single_seed got=%h late=%h want 2a", cap_din, cap_din_late);
    end
    checks++;
    if (cap_wait !== 3 || cap_rv !== 4'b0010 || cap_rd !== 6'h15 || cap_rr !== 2'b10 || cap_err !== 1'b0) begin
      errors++; $display("FAIL single_resp wait=%0d rv=%b data=%h res=%h err=%b want 3/0010/15/2/0",
                         cap_wait, cap_rv, cap_rd, cap_rr, cap_err);
    end
    checks++;
    if (cap_rv_after !== 4'b0 || cap_rd_after !== 6'h0 || cap_busy_after !== 1'b0) begin
      errors++; $display("FAIL single_clear rv=%b data=%h busy=%b want 0000/00/0",
                         cap_rv_after, cap_rd_after, cap_busy_after);
    end
  endtask

  task automatic test_wrap();
    do_txn(4'b0100, 24'h0, 1'b0, 1'b0, 1, 6'h01, 2'b01);
    checks++;
    if (cap_gnt !== 4'b0100) begin
      errors++; $display("FAIL wrap_first got=%b want=0100", cap_gnt);
    end
    do_txn(4'b0101, 24'h0, 1'b0, 1'b0, 1, 6'h02, 2'b01);
    checks++;
    if (cap_gnt !== 4'b0001 || cap_rv !== 4'b0001) begin
      errors++; $display("FAIL wrap_past3 gnt=%b rv=%b want 0001", cap_gnt, cap_rv);
    end
    do_txn(4'b0101, 24'h0, 1'b0, 1'b0, 1, 6'h03, 2'b01);
    checks++;
    if (cap_gnt !== 4'b0100 || cap_rv !== 4'b0100) begin
      errors++; $display("FAIL wrap_then2 gnt=%b rv=%b want 0100", cap_gnt, cap_rv);
    end
  endtask

  task automatic test_timeout();
    do_txn(4'b0010, 24'h0, 1'b0, 1'b0, -1, 6'h3F, 2'b11);
    checks++;
    if (cap_gnt !== 4'b0010 || cap_wait !== 64) begin
      errors++; $display("FAIL timeout_len gnt=%b wait=%0d want 0010/64", cap_gnt, cap_wait);
    end
    checks++;
    if (cap_rv !== 4'b0010 || cap_err !== 1'b1 || cap_rd !== 6'h0 || cap_rr !== 2'b0) begin
      errors++; $display("FAIL timeout_resp rv=%b err=%b data=%h res=%h want 0010/1/00/0",
                         cap_rv, cap_err, cap_rd, cap_rr);
    end
    // pointer moved past 1 to 2: search 2,3,0 picks requester 0
    do_txn(4'b0011, {6'h0, 6'h0, 6'h0, 6'h1C}, 1'b0, 1'b0, 1, 6'h2E, 2'b01);
    checks++;
    if (cap_gnt !== 4'b0001 || cap_din !== 6'h1C) begin
      errors++; $display("FAIL timeout_next_gnt gnt=%b seed=%h want 0001/1c", cap_gnt, cap_din);
    end
    checks++;
    if (cap_wait !== 1 || cap_rv !== 4'b0001 || cap_rd !== 6'h2E || cap_err !== 1'b0) begin
      errors++; $display("FAIL timeout_next_resp wait=%0d rv=%b data=%h err=%b want 1/0001/2e/0",
                         cap_wait, cap_rv, cap_rd, cap_err);
    end
  endtask

  task automatic test_done_timeout_coincide();
    do_txn(4'b0100, 24'h0, 1'b0, 1'b0, 64, 6'h2B, 2'b01);
    checks++;
    if (cap_wait !== 64 || cap_rv !== 4'b0100 || cap_err !== 1'b0 || cap_rd !== 6'h2B || cap_rr !== 2'b01) begin
      errors++; $display("FAIL coincide wait=%0d rv=%b err=%b data=%h res=%h want 64/0100/0/2b/1",
                         cap_wait, cap_rv, cap_err, cap_rd, cap_rr);
    end
    // stray done while idle
    eng_done = 1'b1; eng_data_out = 6'h3F; eng_result = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (resp_valid !== 4'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL stray_idle[%0d] rv=%b busy=%b want 0000/0", i, resp_valid, busy);
      end
    end
    eng_done = 1'b0;
    // stray done during ISSUE must not end the wait early
    do_txn(4'b0001, {6'h0, 6'h0, 6'h0, 6'h05}, 1'b0, 1'b1, 2, 6'h0A, 2'b10);
    checks++;
    if (cap_gnt !== 4'b0001 || cap_wait !== 2 || cap_rd !== 6'h0A || cap_rr !== 2'b10) begin
      errors++; $display("FAIL stray_issue gnt=%b wait=%0d data=%h res=%h want 0001/2/0a/2",
                         cap_gnt, cap_wait, cap_rd, cap_rr);
    end
  endtask

  task automatic test_reset_mid_wait();
    req = 4'b0010; seed_in = {6'h0, 6'h0, 6'h27, 6'h0};
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++; $display("FAIL rstw_grant got=%b want=0010", gnt);
    end
    req = '0;
    step(); step();
    #1;
    rst = 1'b1;
    eng_done = 1'b1; eng_data_out = 6'h33; eng_result = 2'b01;
    #1;
    checks++;
    if ({gnt, resp_valid, resp_data, resp_result, resp_err, busy, eng_start, eng_data_in} !== 25'd0) begin
      errors++;
      $display("FAIL rstw_async got=%h want=0",
               {gnt, resp_valid, resp_data, resp_result, resp_err, busy, eng_start, eng_data_in});
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (resp_valid !== 4'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rstw_noresp[%0d] rv=%b busy=%b want 0000/0", i, resp_valid, busy);
      end
    end
    eng_done = 1'b0;
    do_txn(4'b0011, 24'h0, 1'b0, 1'b0, 1, 6'h11, 2'b00);
    checks++;
    if (cap_gnt !== 4'b0001) begin
      errors++; $display("FAIL rstw_ptr0 got=%b want=0001", cap_gnt);
    end
    do_txn(4'b1000, {6'h2D, 18'h0}, 1'b0, 1'b0, 1, 6'h12, 2'b11);
    checks++;
    if (cap_gnt !== 4'b1000 || cap_din !== 6'h2D || cap_rv !== 4'b1000 || cap_rd !== 6'h12) begin
      errors++; $display("FAIL rstw_req3 gnt=%b seed=%h rv=%b data=%h want 1000/2d/1000/12",
                         cap_gnt, cap_din, cap_rv, cap_rd);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_timeout();
    test_done_timeout_coincide();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
